// File: rtl/control_pkg.sv
// control_pkg: shared encodings for the control unit.
package control_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_MOV = 3'b100
  } alu_ctrl_t;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates a condition field against {N,Z,C,V}.
module cond_check
  import control_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  always_comb begin
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: combinational instruction decode with a conditional flag register.
module control_unit
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] opcode,
  input  logic [3:0]  ALUFlags,
  output logic        MemToReg,
  output logic        MemWrite,
  output logic        branch,
  output logic [2:0]  ALUControl,
  output logic        ALUSrc,
  output logic        RegDst,
  output logic        RegWrite,
  output logic [3:0]  Flags
);
  logic [1:0] op;
  logic [3:0] cmd;
  logic imm, s, pass, en, dp_ok;
  logic rw, mw, br, upd;
  alu_ctrl_t alu;
  assign op  = opcode[7:6];
  assign imm = opcode[5];
  assign cmd = opcode[4:1];
  assign s   = opcode[0];
  assign dp_ok = cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_AND ||
                 cmd == CMD_ORR || cmd == CMD_MOV || cmd == CMD_CMP;
  cond_check u_cond (.cond(opcode[11:8]), .flags(Flags), .pass(pass));
  always_comb begin
    alu = ALU_ADD;
    ALUSrc = 1'b0;
    RegDst = 1'b0;
    MemToReg = 1'b0;
    rw = 1'b0;
    mw = 1'b0;
    br = 1'b0;
    upd = 1'b0;
    case (op)
      OP_DP: if (dp_ok) begin
        alu = cmd == CMD_ADD ? ALU_ADD :
              (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
              cmd == CMD_AND ? ALU_AND :
              cmd == CMD_ORR ? ALU_ORR : ALU_MOV;
        ALUSrc = imm;
        rw = cmd != CMD_CMP;
        upd = s || cmd == CMD_CMP;
      end
      // I=0 selects the immediate offset for memory instructions
      OP_MEM: begin
        alu = opcode[3] ? ALU_ADD : ALU_SUB;
        ALUSrc = !imm;
        MemToReg = s;
        RegDst = !s;
        rw = s;
        mw = !s;
      end
      OP_BR: if (!opcode[4]) begin
        br = 1'b1;
        ALUSrc = 1'b1;
      end
      default: ;
    endcase
  end
  assign en = pass && !rst;
  assign ALUControl = alu;
  assign RegWrite = rw && en;
  assign MemWrite = mw && en;
  assign branch = br && en;
  always_ff @(posedge clk)
    if (rst) Flags <= 4'b0000;
    else if (upd && pass) Flags <= ALUFlags;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized and directed checks against a behavioural model.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] opcode = 12'hE1A;
  logic [3:0] ALUFlags = 4'b0000;
  logic MemToReg, MemWrite, branch, ALUSrc, RegDst, RegWrite;
  logic [2:0] ALUControl;
  logic [3:0] Flags;
  int checks = 0;
  int failures = 0;
  logic [3:0] m_flags = 4'b0000;
  logic [9:0] exp_v;
  bit go = 1'b0;
  localparam logic [3:0] DP_CMD [6] = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd13, 4'd10};
  localparam logic [2:0] DP_ALU [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ALUFlags(ALUFlags),
    .MemToReg(MemToReg), .MemWrite(MemWrite), .branch(branch),
    .ALUControl(ALUControl), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .RegWrite(RegWrite), .Flags(Flags)
  );

  always #5 clk = ~clk;

  function automatic logic passes(input logic [3:0] cond, input logic [3:0] fl);
    logic n, z, c, v;
    logic [15:0] t;
    {n, z, c, v} = fl;
    t = {1'b0, 1'b1, z | (n ^ v), !z & !(n ^ v), n ^ v, !(n ^ v), !c | z, c & !z,
         !v, v, !n, n, !c, c, !z, z};
    return t[cond];
  endfunction

  // {upd, MemToReg, MemWrite, branch, ALUControl[2:0], ALUSrc, RegDst, RegWrite}
  function automatic logic [9:0] model(input logic r, input logic [11:0] o, input logic [3:0] fl);
    logic p, m2r, mw, br, src, dst, rw, upd;
    logic [2:0] alu;
    p = passes(o[11:8], fl) && !r;
    {m2r, mw, br, src, dst, rw, upd, alu} = '0;
    if (o[7:6] == 2'd0) begin
      for (int i = 0; i < 6; i++)
        if (o[4:1] == DP_CMD[i]) begin
          alu = DP_ALU[i];
          src = o[5];
          rw = (i != 5) && p;
          upd = (i == 5 || o[0]) && p;
        end
    end else if (o[7:6] == 2'd1) begin
      src = !o[5];
      alu = o[3] ? 3'd0 : 3'd1;
      m2r = o[0];
      rw = o[0] && p;
      mw = !o[0] && p;
      dst = !o[0];
    end else if (o[7:6] == 2'd2 && !o[4]) begin
      br = p;
      src = 1'b1;
    end
    return {upd, m2r, mw, br, alu, src, dst, rw};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (opcode=%h rst=%b)", name, act, exp, opcode, rst);
    end
  endtask

  task automatic apply(input logic r, input logic [11:0] o, input logic [3:0] f);
    logic [9:0] u;
    @(posedge clk);
    u = model(rst, opcode, m_flags);
    m_flags = rst ? 4'b0000 : (u[9] ? ALUFlags : m_flags);
    #1;
    rst = r;
    opcode = o;
    ALUFlags = f;
    #2;
  endtask

  always @(negedge clk)
    if (go) begin
      exp_v = model(rst, opcode, m_flags);
      chk("outputs", {7'd0, MemToReg, MemWrite, branch, ALUControl, ALUSrc, RegDst, RegWrite},
          {7'd0, exp_v[8:0]});
      chk("flags", {12'd0, Flags}, {12'd0, m_flags});
    end

  initial begin
    apply(1'b1, 12'hE1A, 4'h0);
    go = 1'b1;
    apply(1'b0, 12'hE1A, 4'h0);
    chk("reset_flags", Flags, 4'b0000);
    chk("mov_alu", ALUControl, 3'b100);
    chk("mov_src", ALUSrc, 1'b0);
    chk("mov_rw", RegWrite, 1'b1);
    apply(1'b0, 12'hE3A, 4'h0);
    chk("movi_src", ALUSrc, 1'b1);
    apply(1'b0, 12'hE08, 4'h0);
    chk("add", {ALUControl, ALUSrc, RegWrite, MemWrite}, 6'b000_0_1_0);
    apply(1'b0, 12'hE28, 4'h0);
    chk("addi", {ALUControl, ALUSrc, RegWrite, MemWrite}, 6'b000_1_1_0);
    apply(1'b0, 12'hE04, 4'h0);
    chk("sub", {ALUControl, ALUSrc, RegWrite, MemWrite}, 6'b001_0_1_0);
    apply(1'b0, 12'hE24, 4'h0);
    chk("subi", {ALUControl, ALUSrc, RegWrite, MemWrite}, 6'b001_1_1_0);
    apply(1'b0, 12'hE15, 4'b0100);
    chk("cmp", {RegWrite, ALUControl}, 4'b0_001);
    apply(1'b0, 12'hEAF, 4'h0);
    chk("cmp_flags", Flags, 4'b0100);
    chk("b_al", branch, 1'b1);
    apply(1'b0, 12'h0AF, 4'h0);
    chk("b_eq", branch, 1'b1);
    apply(1'b0, 12'h1AF, 4'h0);
    chk("b_ne", branch, 1'b0);
    apply(1'b0, 12'hE58, 4'h0);
    chk("str", {MemWrite, RegDst, ALUSrc, RegWrite}, 4'b1110);
    apply(1'b0, 12'hE59, 4'h0);
    chk("ldr", {MemToReg, RegWrite, MemWrite}, 3'b110);
    apply(1'b0, 12'hE15, 4'b1000);
    apply(1'b0, 12'hBAF, 4'h0);
    chk("flags_n", Flags, 4'b1000);
    chk("b_lt", branch, 1'b1);
    apply(1'b0, 12'hDAF, 4'h0);
    chk("b_le", branch, 1'b1);
    apply(1'b0, 12'hAAF, 4'h0);
    chk("b_ge", branch, 1'b0);
    apply(1'b0, 12'hCAF, 4'h0);
    chk("b_gt", branch, 1'b0);
    apply(1'b0, 12'hF08, 4'h0);
    chk("never", RegWrite, 1'b0);
    apply(1'b0, 12'hEC0, 4'h0);
    chk("op11", {MemToReg, MemWrite, branch, ALUControl, ALUSrc, RegDst, RegWrite}, 9'd0);
    apply(1'b1, 12'hE59, 4'hF);
    chk("rst_gate", {RegWrite, MemWrite, branch}, 3'b000);
    apply(1'b0, 12'hE1A, 4'h0);
    chk("rst_flags", Flags, 4'b0000);
    for (int i = 0; i < 500; i++)
      apply($urandom_range(15) == 0, 12'($urandom), 4'($urandom));
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
